fcmp_pipe: RTL and testbench

- Pipelined single-precision compare unit; it responds to the FPU dispatcher's compare requests.
- Supported operations: FEQ.S, FLT.S and FLE.S.
- Accepts one operand pair per cycle over a valid/ready handshake.
- Returns a 32-bit result word (0 or 1) and an invalid-operation flag two cycles later, with full backpressure support.

---
 rtl/fcmp_pipe.sv | 165 ++++++++++++++++
 tb/tb_fcmp_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcmp_pipe.sv
// rtl/fcmp_pipe.sv - two-stage binary32 compare unit (feq/flt/fle) with valid/ready flow control
// S1 holds decoded operands and NaN/zero classification; S2 holds the final result word.
module fcmp_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [1:0]       op,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic             nv,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {
    OP_FEQ = 2'b00,
    OP_FLT = 2'b01,
    OP_FLE = 2'b10,
    OP_RSV = 2'b11
  } op_t;

  logic             rst_done;
  logic             s1_valid;
  logic             s1_sgn1, s1_sgn2;
  logic [7:0]       s1_exp1, s1_exp2;
  logic [22:0]      s1_man1, s1_man2;
  logic             s1_nan1, s1_nan2;
  logic             s1_snan1, s1_snan2;
  logic             s1_both_zero;
  op_t              s1_op;
  logic [TAG_W-1:0] s1_tag;

  logic s2_adv, s1_adv, accept;

  logic d_nan1, d_nan2, d_snan1, d_snan2, d_both_zero;

  logic [30:0] mag1, mag2;
  logic        mag_eq, mag_lt, mag_gt;
  logic        eq, lt;
  logic        any_nan, any_snan;
  logic        cmp_d, nv_d;

  // in_ready is held low until the first clock edge after reset release.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = rst_done && s1_adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    d_nan1      = (&x1[30:23]) && (|x1[22:0]);
    d_nan2      = (&x2[30:23]) && (|x2[22:0]);
    d_snan1     = d_nan1 && !x1[22];
    d_snan2     = d_nan2 && !x2[22];
    d_both_zero = (x1[30:0] == 31'd0) && (x2[30:0] == 31'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_sgn1      <= 1'b0;
      s1_sgn2      <= 1'b0;
      s1_exp1      <= 8'd0;
      s1_exp2      <= 8'd0;
      s1_man1      <= 23'd0;
      s1_man2      <= 23'd0;
      s1_nan1      <= 1'b0;
      s1_nan2      <= 1'b0;
      s1_snan1     <= 1'b0;
      s1_snan2     <= 1'b0;
      s1_both_zero <= 1'b0;
      s1_op        <= OP_FEQ;
      s1_tag       <= '0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_sgn1      <= x1[31];
        s1_sgn2      <= x2[31];
        s1_exp1      <= x1[30:23];
        s1_exp2      <= x2[30:23];
        s1_man1      <= x1[22:0];
        s1_man2      <= x2[22:0];
        s1_nan1      <= d_nan1;
        s1_nan2      <= d_nan2;
        s1_snan1     <= d_snan1;
        s1_snan2     <= d_snan2;
        s1_both_zero <= d_both_zero;
        s1_op        <= op_t'(op);
        s1_tag       <= tag;
      end
    end
  end

  // Sign-magnitude ordering; for two negatives the larger magnitude is the smaller value.
  always_comb begin
    mag1     = {s1_exp1, s1_man1};
    mag2     = {s1_exp2, s1_man2};
    mag_eq   = (mag1 == mag2);
    mag_lt   = (mag1 < mag2);
    mag_gt   = !mag_lt && !mag_eq;
    any_nan  = s1_nan1 || s1_nan2;
    any_snan = s1_snan1 || s1_snan2;
    eq       = s1_both_zero || ((s1_sgn1 == s1_sgn2) && mag_eq);
    lt       = 1'b0;
    if (s1_both_zero) begin
      lt = 1'b0;
    end else if (s1_sgn1 != s1_sgn2) begin
      lt = s1_sgn1;
    end else if (s1_sgn1) begin
      lt = mag_gt;
    end else begin
      lt = mag_lt;
    end
    cmp_d = 1'b0;
    nv_d  = 1'b0;
    case (s1_op)
      OP_FEQ: begin
        cmp_d = eq && !any_nan;
        nv_d  = any_snan;
      end
      OP_FLT: begin
        cmp_d = lt && !any_nan;
        nv_d  = any_nan;
      end
      OP_FLE: begin
        cmp_d = (lt || eq) && !any_nan;
        nv_d  = any_nan;
      end
      default: begin
        cmp_d = 1'b0;
        nv_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= 32'd0;
      nv        <= 1'b0;
      out_tag   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        y       <= {31'd0, cmp_d};
        nv      <= nv_d;
        out_tag <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_fcmp_pipe.sv
// tb/tb_fcmp_pipe.sv - directed table, backpressure/reset sequences and a streamed sweep for fcmp_pipe
module tb_fcmp_pipe;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      x1 = 32'd0;
  logic [31:0]      x2 = 32'd0;
  logic [1:0]       op = 2'd0;
  logic [TAG_W-1:0] tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      y;
  logic             nv;
  logic [TAG_W-1:0] out_tag;

  int total = 0;
  int bad = 0;

  fcmp_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .op(op), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .nv(nv), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        y;
    logic        nv;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // binary32 -> binary64 bit conversion so the reference uses native real compares
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [23:0] mm;
    int s;
    if (f[30:23] == 8'hFF) begin
      d = {f[31], 11'h7FF, f[22:0], 29'd0};
    end else if (f[30:23] == 8'd0) begin
      if (f[22:0] == 23'd0) begin
        d = {f[31], 63'd0};
      end else begin
        mm = {1'b0, f[22:0]};
        s = 0;
        while (!mm[23]) begin
          mm = mm << 1;
          s++;
        end
        d = {f[31], 11'(897 - s), mm[22:0], 29'd0};
      end
    end else begin
      d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [1:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic na, nb, sa, sb, c, v;
    real ra, rb;
    na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    sa = na && !a[22];
    sb = nb && !b[22];
    ra = f2r(a);
    rb = f2r(b);
    case (o)
      2'd0: begin c = (ra == rb); v = sa || sb; end
      2'd1: begin c = (ra < rb);  v = na || nb; end
      2'd2: begin c = (ra <= rb); v = na || nb; end
      default: begin c = 1'b0; v = 1'b1; end
    endcase
    return {c, v};
  endfunction

  // scoreboard for the streamed sweep: {tag, cmp, nv}
  logic [TAG_W+1:0] exp_q[$];
  logic             sb_on = 1'b0;
  logic             rnd_rdy = 1'b0;
  logic             held = 1'b0;
  logic [63:0]      held_val;

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (sb_on && !rst) begin
      if (held) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_data", {27'd0, out_tag, y, nv}, held_val);
      end
      if (out_valid && out_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'd1, 64'd0);
        end else begin
          chk("sweep_result", {27'd0, out_tag, y, nv},
              {27'd0, exp_q[0][TAG_W+1:2], 31'd0, exp_q[0][1], exp_q[0][0]});
          void'(exp_q.pop_front());
        end
      end else if (out_valid) begin
        held = 1'b1;
        held_val = {27'd0, out_tag, y, nv};
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    in_valid = 1'b1;
    op = o;
    x1 = a;
    x2 = b;
    tag = t;
  endtask

  function automatic logic [22:0] pick_man(input int sel);
    case (sel)
      0: return 23'd0;
      1: return 23'd1;
      2: return 23'h400000;
      3: return 23'h7FFFFF;
      default: return 23'($urandom());
    endcase
  endfunction

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    vecs[0]  = '{2'd0, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0};
    vecs[1]  = '{2'd1, 32'h3F800000, 32'h40000000, 1'b1, 1'b0};
    vecs[2]  = '{2'd2, 32'h40000000, 32'h3F800000, 1'b0, 1'b0};
    vecs[3]  = '{2'd0, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
    vecs[4]  = '{2'd1, 32'h80000000, 32'h00000000, 1'b0, 1'b0};
    vecs[5]  = '{2'd1, 32'hC0000000, 32'hBF800000, 1'b1, 1'b0};
    vecs[6]  = '{2'd0, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b0};
    vecs[7]  = '{2'd0, 32'h7F800001, 32'h00000000, 1'b0, 1'b1};
    vecs[8]  = '{2'd2, 32'h7FC00000, 32'h7FC00000, 1'b0, 1'b1};
    vecs[9]  = '{2'd3, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1};
    vecs[10] = '{2'd1, 32'h00000001, 32'h00000002, 1'b1, 1'b0};
    vecs[11] = '{2'd1, 32'hFF800000, 32'h7F800000, 1'b1, 1'b0};
    vecs[12] = '{2'd2, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
    vecs[13] = '{2'd1, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b1};
    vecs[14] = '{2'd2, 32'hBF800000, 32'hBF800000, 1'b1, 1'b0};
    vecs[15] = '{2'd1, 32'hBF800000, 32'h00000000, 1'b1, 1'b0};
    vecs[16] = '{2'd0, 32'hFF800001, 32'h00000000, 1'b0, 1'b1};
    vecs[17] = '{2'd1, 32'h807FFFFF, 32'h80000001, 1'b1, 1'b0};
    vecs[18] = '{2'd2, 32'h7F800000, 32'h7F7FFFFF, 1'b0, 1'b0};

    // reset state
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_y", {32'd0, y}, 64'd0);
    chk("rst_nv", {63'd0, nv}, 64'd0);
    chk("rst_out_tag", {60'd0, out_tag}, 64'd0);
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("ready_after_rst", {63'd0, in_ready}, 64'd1);
    step();

    // directed table with latency check
    for (int i = 0; i < 19; i++) begin
      set_req(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i));
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_not_early", i), {63'd0, out_valid}, 64'd0);
      step();
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("vec%0d_y", i), {32'd0, y}, {63'd0, vecs[i].y});
      chk($sformatf("vec%0d_nv", i), {63'd0, nv}, {63'd0, vecs[i].nv});
      chk($sformatf("vec%0d_tag", i), {60'd0, out_tag}, {60'd0, 4'(i)});
      step();
    end

    // backpressure: tags 1,2,3 with out_ready low
    out_ready = 1'b0;
    set_req(2'd1, 32'h3F800000, 32'h40000000, 4'd1);
    @(negedge clk);
    chk("bp_accept1", {63'd0, in_ready}, 64'd1);
    step();
    set_req(2'd2, 32'h40000000, 32'h3F800000, 4'd2);
    @(negedge clk);
    chk("bp_accept2", {63'd0, in_ready}, 64'd1);
    step();
    set_req(2'd0, 32'h3F800000, 32'h3F800000, 4'd3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_hold_tag", {60'd0, out_tag}, 64'd1);
      chk("bp_hold_y", {32'd0, y}, 64'd1);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_tag1", {60'd0, out_tag}, 64'd1);
    chk("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_tag2_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_tag2", {60'd0, out_tag}, 64'd2);
    chk("bp_tag2_y", {32'd0, y}, 64'd0);
    step();
    @(negedge clk);
    chk("bp_tag3_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_tag3", {60'd0, out_tag}, 64'd3);
    chk("bp_tag3_y", {32'd0, y}, 64'd1);
    step();
    @(negedge clk);
    chk("bp_empty", {63'd0, out_valid}, 64'd0);
    step();

    // reset with two requests in flight
    set_req(2'd0, 32'h3F800000, 32'h3F800000, 4'd5);
    step();
    set_req(2'd1, 32'h3F800000, 32'h40000000, 4'd6);
    step();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midrst_no_stale", {63'd0, out_valid}, 64'd0);
      step();
    end
    @(negedge clk);
    chk("midrst_ready", {63'd0, in_ready}, 64'd1);
    step();

    // streamed sweep with random out_ready
    sb_on = 1'b1;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 9; k++) begin
        logic [31:0] a, b;
        logic [1:0]  o;
        int n;
        a = {1'($urandom()), 8'(i), pick_man(int'($urandom_range(0, 5)))};
        if (k == 0 && $urandom_range(0, 1) == 1)
          b = {1'($urandom()), a[30:0]};
        else
          b = {1'($urandom()), 8'((i + k * 29) % 256), pick_man(int'($urandom_range(0, 5)))};
        o = 2'((i * 9 + k) % 3);
        if ($urandom_range(0, 31) == 0) o = 2'd3;
        set_req(o, a, b, 4'((i * 9 + k) % 16));
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
          step();
          @(negedge clk);
          n++;
        end
        if (!in_ready) begin
          chk("sweep_in_ready_timeout", 64'd0, 64'd1);
        end else begin
          exp_q.push_back({tag, model(o, a, b)});
        end
        step();
        if ($urandom_range(0, 7) == 0) begin
          in_valid = 1'b0;
          step();
        end
      end
    end
    in_valid = 1'b0;
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) step();
    chk("sweep_drained", 64'(exp_q.size()), 64'd0);
    sb_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
